// File: rtl/regs_file_param_if.sv
// Register-file access bundle: two read ports, one write port, bulk-clear request and busy flag.
// The master drives addresses, write data and requests; the slave (register file) returns read data and BUSY.
interface regs_file_param_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    A1;
  logic [AW-1:0]    A2;
  logic [AW-1:0]    A3;
  logic [WIDTH-1:0] WD3;
  logic             WE3;
  logic             CLR;
  logic [WIDTH-1:0] RD1;
  logic [WIDTH-1:0] RD2;
  logic             BUSY;

  modport master (
    output A1, A2, A3, WD3, WE3, CLR,
    input  RD1, RD2, BUSY
  );

  modport slave (
    input  A1, A2, A3, WD3, WE3, CLR,
    output RD1, RD2, BUSY
  );
endinterface

// File: rtl/regs_file_param.sv
// Parametrised three-address register file with a sequential bulk-clear sweep.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding while idle.
module regs_file_param #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               reset,
  regs_file_param_if.slave   bus
);
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam bit          ZR      = (ZERO_REG != 0);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [AW-1:0]    ptr_q;
  logic [AW-1:0]    ptr_d;
  logic             busy_q;
  logic             wr_en_c;
  logic             sweep_en_c;
  logic             write_ok_c;
  logic [WIDTH-1:0] rd1_c;
  logic [WIDTH-1:0] rd2_c;
  logic [WIDTH-1:0] regs [DEPTH];

  // A write is dropped when it targets the hardwired zero register.
  assign write_ok_c = bus.WE3 && !(ZR && (bus.A3 == '0));

  // State, sweep pointer and registered busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= (state_d == CLEAR);
    end
  end

  // Next-state logic; CLR is ignored once a sweep is running.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wr_en_c    = 1'b0;
    sweep_en_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        wr_en_c = write_ok_c;
        if (bus.CLR) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        sweep_en_c = 1'b1;
        if (ptr_q == LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Storage array: writes only while idle, one entry cleared per sweep cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en_c) begin
      regs[bus.A3] <= bus.WD3;
    end else if (sweep_en_c) begin
      regs[ptr_q] <= '0;
    end
  end

  // Read port 1; the zero-register rule overrides any forwarded value.
  always_comb begin
    rd1_c = regs[bus.A1];
`ifdef REGFILE_BYPASS_EN
    if ((state_q == IDLE) && write_ok_c && (bus.A1 == bus.A3)) begin
      rd1_c = bus.WD3;
    end
`endif
    if (ZR && (bus.A1 == '0)) begin
      rd1_c = '0;
    end
  end

  // Read port 2; same rules as port 1.
  always_comb begin
    rd2_c = regs[bus.A2];
`ifdef REGFILE_BYPASS_EN
    if ((state_q == IDLE) && write_ok_c && (bus.A2 == bus.A3)) begin
      rd2_c = bus.WD3;
    end
`endif
    if (ZR && (bus.A2 == '0)) begin
      rd2_c = '0;
    end
  end

  assign bus.RD1  = rd1_c;
  assign bus.RD2  = rd2_c;
  assign bus.BUSY = busy_q;

endmodule

// File: doc/regs_file_param.md
Name: regs_file_param

Overview:
- Parametrised successor to the MIPS three-address register file: two combinational read ports, one clocked write port.
- Width and depth are configurable, and register 0 can optionally be hardwired to zero.
- Adds a sequential bulk-clear engine (FSM plus sweep counter) used by the core on context flush.
- Sits in the decode stage of the datapath, feeding ALU operand muxes.

Parameters:
WIDTH, 32, data width of each register in bits
DEPTH, 32, number of registers; must be a power of two, at least 2
AW, $clog2(DEPTH), address width (derived, do not override)
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is an ordinary register

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
A1  input  AW  read address, port 1
A2  input  AW  read address, port 2
A3  input  AW  write address
WD3  input  WIDTH  write data
WE3  input  1  write enable
CLR  input  1  bulk-clear request, sampled on rising edge
RD1  output  WIDTH  read data, port 1
RD2  output  WIDTH  read data, port 2
BUSY  output  1  high while the clear sweep is in progress

Behaviour:
- Reset (async, reset=1): all DEPTH entries = 0; FSM = IDLE; sweep pointer = 0; BUSY = 0. RD1/RD2 therefore read 0 during and after reset.
- Reads: combinational, zero latency.
  - RDn = regs[An].
  - If ZERO_REG=1 and An=0, RDn = 0 regardless of stored value.
  - Without the optional bypass, a read of an address being written returns the old value until the edge.
- Write: on rising edge, when FSM=IDLE and WE3=1, regs[A3] <= WD3.
  - If ZERO_REG=1 and A3=0, the write is dropped.
  - When FSM=CLEAR, WE3 is ignored; the write is lost, and the caller must watch BUSY.
- FSM, states IDLE and CLEAR:
  - IDLE: CLR=1 at an edge moves to CLEAR with ptr=0; BUSY rises the cycle after CLR is sampled.
  - IDLE with CLR=1 and WE3=1 in the same cycle: the write commits at that edge; the sweep then clears it.
  - CLEAR: each edge sets regs[ptr] <= 0 and increments ptr.
  - When ptr=DEPTH-1 is cleared, the FSM returns to IDLE, ptr wraps to 0, and BUSY falls.
  - The sweep lasts exactly DEPTH cycles.
  - CLR asserted while in CLEAR is ignored; no restart or extension.
- Reads during CLEAR return current contents: entries below ptr already read 0, entries at or above ptr still hold old data.
- reset asserted mid-sweep: immediate return to IDLE; all entries 0, BUSY=0, ptr=0.
- BUSY is a registered output (FSM==CLEAR); it has no combinational path from CLR.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. If FSM=IDLE, WE3=1, An=A3 and the write is not dropped by ZERO_REG, then RDn = WD3 in the same cycle. The ZERO_REG rule takes precedence; no forwarding is allowed during CLEAR.
- Undefined: no forwarding path; reads always return stored contents.
- Both builds must pass the full test plan, with scenario 2 expectations selected by the macro.

Test Plan:
- Write/readback: reset, then write regs[i] = i*16 for i=1..31 (one write per cycle); read via A1 and A2 -> RD1 = RD2 = i*16 for every i.
- Same-cycle read of write address: A1=A3=5, WD3=32'hDEADBEEF, WE3=1, old value 32'h50 -> RD1 before the edge is 32'hDEADBEEF with REGFILE_BYPASS_EN, 32'h50 without; after the edge, 32'hDEADBEEF in both builds.
- Zero register: ZERO_REG=1, write 32'hFFFFFFFF to A3=0 -> RD1 (A1=0) = 0. With ZERO_REG=0, the same write -> RD1 = 32'hFFFFFFFF.
- Bulk clear: fill regs with nonzero values, pulse CLR for 1 cycle -> BUSY high for exactly 32 cycles starting the next cycle. At sweep cycle 10, regs[0..9] read 0 and regs[10..31] are unchanged; after BUSY falls, all entries read 0.
- Write during clear: write A3=7, WD3=32'h1234 while BUSY=1 -> regs[7] reads 0 after the sweep. The same write issued one cycle after BUSY falls -> reads 32'h1234.
- Reset mid-sweep: assert reset at sweep cycle 5 -> BUSY=0 and all RD = 0 immediately. After release, a CLR pulse yields a fresh 32-cycle sweep.
